// File: rtl/target_tracker_pkg.sv
// target_tracker_pkg: shared types and width helpers for the colour-target
// tracker.
//   state_t      - frame-processing FSM state (ACCUM, EVAL, PUBLISH)
//   count_width  - bits needed to hold a whole frame's worth of hits
//   index_width  - bits needed to index n items, never less than 1
package target_tracker_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        EVAL    = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    function automatic int count_width(input int h_active, input int v_active);
        return $clog2(h_active * v_active + 1);
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/target_zone_accum.sv
// target_zone_accum: per-class bank of N_ZONES saturating hit counters.
// Ports:
//   clk    - pixel clock
//   reset  - synchronous, active-high
//   clear  - synchronous clear of every zone counter (end of publish)
//   inc    - count one hit in the selected zone this cycle
//   zone   - zone index of the current pixel
//   zcnt   - current counter values, zone 0 in the low slice
module target_zone_accum #(
    parameter int N_ZONES = 3,
    parameter int COUNT_W = 17,
    parameter int ZONE_W  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              inc,
    input  logic [ZONE_W-1:0]                 zone,
    output logic [N_ZONES-1:0][COUNT_W-1:0]   zcnt
);

    // NOTE: these are a handful of flops, not a RAM, so they take the reset
    // directly; a true memory array would be cleared by logic instead.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            zcnt <= '0;
        end else if (inc) begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (zone == ZONE_W'(z) && zcnt[z] != '1) begin
                    zcnt[z] <= zcnt[z] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/target_tracker.sv
// target_tracker: multi-class colour-target tracker on the VGA pixel clock.
// Accumulates per-class hits in N_ZONES vertical zones, then at each frame end
// evaluates every class (saturating total, argmax zone) through one shared
// unit and publishes debounced results.
// Ports:
//   clk         - pixel clock
//   reset       - synchronous, active-high
//   pix_valid   - active pixel this cycle, raster order
//   class_hit   - per-class hit flags for the current pixel
//   vsync       - active-low vsync level; falling edge closes the frame
//   detected    - debounced detect flag per class
//   direction   - argmax zone per class, class 0 in the LSBs
//   count       - last frame's total hits per class, class 0 in the LSBs
//   frame_valid - one-cycle pulse when the outputs update
module target_tracker
    import target_tracker_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int N_CLASSES   = 2,
    parameter int N_ZONES     = 3,
    parameter int THRESH      = 64,
    parameter int HYST_FRAMES = 2,
    localparam int COUNT_W    = count_width(H_ACTIVE, V_ACTIVE),
    localparam int ZONE_W     = index_width(N_ZONES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_valid,
    input  logic [N_CLASSES-1:0]          class_hit,
    input  logic                          vsync,
    output logic [N_CLASSES-1:0]          detected,
    output logic [N_CLASSES*ZONE_W-1:0]   direction,
    output logic [N_CLASSES*COUNT_W-1:0]  count,
    output logic                          frame_valid
);

    localparam int ZW    = H_ACTIVE / N_ZONES;
    localparam int X_W   = index_width(H_ACTIVE);
    localparam int E_W   = index_width(N_CLASSES);
    localparam int RUN_W = index_width(HYST_FRAMES + 1);
    localparam logic [COUNT_W-1:0] THRESH_C = COUNT_W'(THRESH);

    state_t                              state;
    logic [E_W-1:0]                      eval_idx;
    logic                                vsync_q;
    logic                                frame_end;
    logic [X_W-1:0]                      x;
    logic [ZONE_W-1:0]                   zone;
    logic [N_CLASSES-1:0]                inc;
    logic                                zclear;
    logic [N_ZONES-1:0][COUNT_W-1:0]     zcnt [N_CLASSES];

    logic [N_ZONES-1:0][COUNT_W-1:0]     sel;
    logic [COUNT_W:0]                    sum_ext;
    logic [COUNT_W-1:0]                  best;
    logic [COUNT_W-1:0]                  unit_total;
    logic [ZONE_W-1:0]                   unit_arg;

    logic [N_CLASSES-1:0][COUNT_W-1:0]   sh_total, tot_next, count_r;
    logic [N_CLASSES-1:0][ZONE_W-1:0]    sh_arg, arg_next, dir_r, dir_next;
    logic [N_CLASSES-1:0][RUN_W-1:0]     run_r, run_next;
    logic [N_CLASSES-1:0]                det_r, det_next, hit_frame;

    // Frame end: vsync seen high last cycle and low now. vsync_q resets low so
    // a vsync already low at reset release cannot fake an edge.
    always_ff @(posedge clk) begin
        if (reset) vsync_q <= 1'b0;
        else       vsync_q <= vsync;
    end
    assign frame_end = vsync_q & ~vsync;

    // Column counter advances only while accumulating, so pixels dropped in
    // EVAL/PUBLISH do not skew the next frame's zone positions.
    always_ff @(posedge clk) begin
        if (reset || frame_end) begin
            x <= '0;
        end else if (pix_valid && state == ACCUM) begin
            x <= (x == X_W'(H_ACTIVE - 1)) ? '0 : x + 1'b1;
        end
    end

    // Highest zone whose start column is reached; the last zone absorbs the
    // remainder columns automatically.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        zone = '0;
        for (int z = 1; z < N_ZONES; z++) begin
            if (x >= X_W'(z * ZW)) zone = ZONE_W'(z);
        end
    end

    assign inc    = (state == ACCUM && pix_valid) ? class_hit : '0;
    assign zclear = (state == PUBLISH);

    for (genvar c = 0; c < N_CLASSES; c++) begin : g_class
        target_zone_accum #(
            .N_ZONES (N_ZONES),
            .COUNT_W (COUNT_W),
            .ZONE_W  (ZONE_W)
        ) u_accum (
            .clk   (clk),
            .reset (reset),
            .clear (zclear),
            .inc   (inc[c]),
            .zone  (zone),
            .zcnt  (zcnt[c])
        );
    end

    // Shared evaluation unit for class eval_idx: saturating total and argmax
    // (strict compare, so ties keep the lower zone).
    // NOTE: blocking assignments here chain the partial sum through the loop
    // within one evaluation; sequential state below uses non-blocking only.
    always_comb begin
        sel        = zcnt[eval_idx];
        sum_ext    = '0;
        unit_total = '0;
        unit_arg   = '0;
        best       = sel[0];
        for (int z = 0; z < N_ZONES; z++) begin
            sum_ext    = {1'b0, unit_total} + {1'b0, sel[z]};
            unit_total = sum_ext[COUNT_W] ? '1 : sum_ext[COUNT_W-1:0];
        end
        for (int z = 1; z < N_ZONES; z++) begin
            if (sel[z] > best) begin
                best     = sel[z];
                unit_arg = ZONE_W'(z);
            end
        end
    end

    // Shadow contents after this EVAL cycle, plus the hysteresis decision made
    // from them; the latter is only committed on the last EVAL cycle so all
    // classes publish together on the edge that raises frame_valid.
    always_comb begin
        tot_next           = sh_total;
        arg_next           = sh_arg;
        tot_next[eval_idx] = unit_total;
        arg_next[eval_idx] = unit_arg;
        hit_frame          = '0;
        dir_next           = dir_r;
        det_next           = det_r;
        run_next           = run_r;
        for (int c = 0; c < N_CLASSES; c++) begin
            hit_frame[c] = (tot_next[c] >= THRESH_C);
            if (hit_frame[c]) dir_next[c] = arg_next[c];
            if (hit_frame[c] != det_r[c]) begin
                if (run_r[c] == RUN_W'(HYST_FRAMES - 1)) begin
                    det_next[c] = ~det_r[c];
                    run_next[c] = '0;
                end else begin
                    run_next[c] = run_r[c] + 1'b1;
                end
            end else begin
                run_next[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            eval_idx <= '0;
            sh_total <= '0;
            sh_arg   <= '0;
            count_r  <= '0;
            dir_r    <= '0;
            det_r    <= '0;
            run_r    <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (frame_end) begin
                        state    <= EVAL;
                        eval_idx <= '0;
                    end
                end
                EVAL: begin
                    sh_total <= tot_next;
                    sh_arg   <= arg_next;
                    if (eval_idx == E_W'(N_CLASSES - 1)) begin
                        state   <= PUBLISH;
                        count_r <= tot_next;
                        dir_r   <= dir_next;
                        det_r   <= det_next;
                        run_r   <= run_next;
                    end else begin
                        eval_idx <= eval_idx + 1'b1;
                    end
                end
                PUBLISH: state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

    assign count       = count_r;
    assign direction   = dir_r;
    assign detected    = det_r;
    assign frame_valid = (state == PUBLISH);

endmodule

// File: tb/tb_target_tracker.sv
// tb_target_tracker: directed self-checking bench for target_tracker with a
// small configuration (12x4 frame, 3 zones of 4 columns, 2 classes,
// THRESH=4, HYST_FRAMES=2). Expected frame results are queued when a frame
// end is driven and compared when frame_valid appears.
module tb_target_tracker;

    localparam int H  = 12;
    localparam int V  = 4;
    localparam int NC = 2;
    localparam int NZ = 3;
    localparam int TH = 4;
    localparam int HY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [1:0]  class_hit;
    logic        vsync;
    logic [1:0]  detected;
    logic [3:0]  direction;
    logic [11:0] count;
    logic        frame_valid;

    target_tracker #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .N_CLASSES   (NC),
        .N_ZONES     (NZ),
        .THRESH      (TH),
        .HYST_FRAMES (HY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .class_hit   (class_hit),
        .vsync       (vsync),
        .detected    (detected),
        .direction   (direction),
        .count       (count),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] count;
        logic [3:0]  dir;
        logic [1:0]  det;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   fv_seen = 0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input int c0, input int c1, input int d0,
                                input int d1, input int t0, input int t1);
        exp_t m;
        m.count = {6'(c1), 6'(c0)};
        m.dir   = {2'(d1), 2'(d0)};
        m.det   = {1'(t1), 1'(t0)};
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full line; pixel x carries class 0 hit h0[x] and class 1 hit h1[x].
    task automatic drive_line(input logic [11:0] h0, input logic [11:0] h1);
        for (int x = 0; x < H; x++) begin
            pix_valid = 1'b1;
            class_hit = {h1[x], h0[x]};
            step();
        end
        pix_valid = 1'b0;
        class_hit = 2'b00;
    endtask

    // Close the frame, optionally present hit pixels during EVAL/PUBLISH, and
    // compare the published results against the queued expectation.
    task automatic close_frame(input exp_t e, input bit junk);
        exp_t want;
        bit   got;
        int   lat;
        sb.push_back(e);
        vsync = 1'b0;
        got   = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (junk) begin
                pix_valid = 1'b1;
                class_hit = 2'b11;
            end
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        want = sb.pop_front();
        check("frame_valid_seen", 32'(got), 32'd1);
        check("frame_valid_latency", 32'(lat), 32'd3);
        check("count", 32'(count), 32'(want.count));
        check("direction", 32'(direction), 32'(want.dir));
        check("detected", 32'(detected), 32'(want.det));
        step();
        pix_valid = 1'b0;
        class_hit = 2'b00;
        vsync     = 1'b1;
        step();
    endtask

    initial begin
        int fv_before;
        reset     = 1'b1;
        pix_valid = 1'b0;
        class_hit = 2'b00;
        vsync     = 1'b0;

        // 1. Reset with a vsync pulse inside it, released with vsync low.
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        check("reset_count", 32'(count), 32'd0);
        check("reset_direction", 32'(direction), 32'd0);
        check("reset_detected", 32'(detected), 32'd0);
        reset = 1'b0;
        repeat (5) step();
        check("post_reset_count", 32'(count), 32'd0);
        check("post_reset_detected", 32'(detected), 32'd0);
        check("no_frame_valid_after_reset", 32'(fv_seen), 32'd0);
        vsync = 1'b1;
        repeat (2) step();

        // 2. Detect: two hit frames, zone 0 = 4 hits, zone 1 = 2 hits.
        drive_line(12'h03F, 12'h000);
        close_frame(mk(6, 0, 0, 0, 0, 0), 1'b0);
        drive_line(12'h03F, 12'h000);
        close_frame(mk(6, 0, 0, 0, 1, 0), 1'b0);

        // 3. Tie-break between zones 1 and 2.
        drive_line(12'h330, 12'h000);
        close_frame(mk(4, 0, 1, 0, 1, 0), 1'b0);

        // 4. Drop: two miss frames with 3 hits in zone 2, direction held.
        drive_line(12'h700, 12'h000);
        close_frame(mk(3, 0, 1, 0, 1, 0), 1'b0);
        drive_line(12'h700, 12'h000);
        close_frame(mk(3, 0, 1, 0, 0, 0), 1'b0);

        // 5. Both classes on a full line, hit pixels during EVAL/PUBLISH that
        //    must not leak into the following (empty) frame.
        drive_line(12'hFFF, 12'hFFF);
        close_frame(mk(12, 12, 0, 0, 0, 0), 1'b1);
        close_frame(mk(0, 0, 0, 0, 0, 0), 1'b0);

        // 6. Mid-frame reset discards the earlier 5 hits.
        fv_before = fv_seen;
        drive_line(12'h01F, 12'h000);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        drive_line(12'h00F, 12'h000);
        close_frame(mk(4, 0, 0, 0, 0, 0), 1'b0);
        repeat (5) step();
        check("pulses_after_mid_reset", 32'(fv_seen - fv_before), 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("total_frame_valid_pulses", 32'(fv_seen), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
